fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 clk  in  1  system clock, 50 MHz; all logic SHALL be synchronous to its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 PixEn  in  1  one-cycle strobe; Hcounter/Vcounter SHALL be treated as holding new values on cycles with PixEn=1 (every 2nd clk).
REQ-004 Hcounter  in  10  horizontal position, 0..799; 0..639 active.
REQ-005 Vcounter  in  10  vertical position, 0..524; 0..479 active.
REQ-006 PixData  out  8  RGB332 byte for the pixel controller.
REQ-007 FbAddr  out  15  frame-buffer RAM address; RAM is single-port, 19200 x 8 (160x120), with 1-cycle synchronous read.
REQ-008 FbWe  out  1  RAM write enable.
REQ-009 FbWData  out  8  RAM write data.
REQ-010 FbRData  in  8  RAM read data, valid the cycle after the read address.
REQ-011 HostReq  in  1  host write request, level; held until HostAck.
REQ-012 HostAddr  in  15  host write address.
REQ-013 HostData  in  8  host write data.
REQ-014 HostAck  out  1  one-cycle pulse; write accepted.
REQ-015 Underrun  out  1  sticky flag; a display fetch missed its deadline.

Function
REQ-016 GroupStart SHALL be PixEn=1 with Hcounter[1:0]=0; each stored byte covers 4x4 screen pixels.
REQ-017 Active means Hcounter<640 and Vcounter<480.
REQ-018 On GroupStart in active area: PixData<=NextByte, registered, visible the next cycle. On GroupStart outside the active area: PixData<=0.
REQ-019 On GroupStart with Hcounter<636, DispPending SHALL be set with DispAddr=(Vcounter>>2)*160+(Hcounter>>2)+1.
REQ-020 On GroupStart with Hcounter=796: let Vn = (Vcounter=524 ? 0 : Vcounter+1); if Vn<480, DispPending SHALL be set with DispAddr=(Vn>>2)*160; otherwise no fetch.
REQ-021 Address arithmetic SHALL be 15-bit unsigned using row*128+row*32; the maximum is 19199.
REQ-022 FSM states and transitions:
 - IDLE: DispPending -> DISP_RD; else HostReq -> HOST_WR; else stay.
 - DISP_RD: FbAddr=DispAddr, FbWe=0, clear DispPending -> DISP_CAP.
 - DISP_CAP: NextByte<=FbRData -> IDLE.
 - HOST_WR: FbAddr=HostAddr, FbWData=HostData, HostAck=1 -> IDLE.
REQ-023 FbWe=1 SHALL occur only in HOST_WR, and only when HostAddr<19200.
REQ-024 If HostAddr>=19200, HostAck SHALL still pulse with FbWe=0 (write dropped).
REQ-025 The display fetch SHALL have strict priority: if DispPending and HostReq are both seen in IDLE, the read is issued first.
REQ-026 Host grants SHALL be at most one every 2 cycles (HOST_WR always returns to IDLE); during blanking the host may take every idle slot.
REQ-027 A GroupStart arriving in any state SHALL set DispPending; worst case to capture is HOST_WR->IDLE->DISP_RD->DISP_CAP (4 clk), which is within the 8-clk group period.
REQ-028 If a GroupStart that would set DispPending arrives while DispPending is already 1: Underrun<=1, and DispAddr is overwritten with the new address.
REQ-029 Outputs SHALL be registered; FbAddr SHALL hold its last value in IDLE/DISP_CAP, and FbWe=0 outside HOST_WR.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state=IDLE, PixData=0, NextByte=0, FbAddr=0, FbWData=0, FbWe=0, HostAck=0, DispPending=0, Underrun=0.
REQ-031 Reset mid-operation (any state, including HOST_WR) SHALL abort with no write and no HostAck; the host SHALL re-request.
REQ-032 After reset, the first line's PixData SHALL be 0 until the first Hcounter=796 prefetch completes.

Verification
REQ-033 RAM preloaded addr=k -> k[7:0]; counters run from H=796, V=524 -> read of addr 0 issued; at H=0,V=0 PixData=8'h00; at H=4 PixData=8'h01; at H=636,V=4 PixData=(160+159)[7:0]=8'h3F.
REQ-034 HostReq held with HostAddr=100, HostData=8'hE0 in the same cycle that DispPending is set -> DISP_RD issued first, HOST_WR follows, HostAck pulses once, RAM[100]=8'hE0.
REQ-035 HostAddr=19200 -> HostAck=1 for one cycle, FbWe never asserted.
REQ-036 V=479, H=796 -> no fetch; V=524, H=796 -> fetch addr 0; during H>=640, PixData=0.
REQ-037 PixEn forced every clk with continuous HostReq -> Underrun rises and stays 1 until rst; rst asserted during HOST_WR -> FbWe=0, HostAck=0, all outputs at reset values.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: video timing in, pixel byte out, host write port and RAM port.
// The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface fb_arbiter_if;
    logic        PixEn;
    logic [9:0]  Hcounter;
    logic [9:0]  Vcounter;
    logic [7:0]  PixData;
    logic [14:0] FbAddr;
    logic        FbWe;
    logic [7:0]  FbWData;
    logic [7:0]  FbRData;
    logic        HostReq;
    logic [14:0] HostAddr;
    logic [7:0]  HostData;
    logic        HostAck;
    logic        Underrun;

    // Host handshake: HostReq is a level held until HostAck, which pulses for exactly
    // one cycle when the write slot is granted (the write itself may be dropped if out of range).
    modport slave (
        input  PixEn, Hcounter, Vcounter, FbRData, HostReq, HostAddr, HostData,
        output PixData, FbAddr, FbWe, FbWData, HostAck, Underrun
    );

    modport master (
        output PixEn, Hcounter, Vcounter, FbRData, HostReq, HostAddr, HostData,
        input  PixData, FbAddr, FbWe, FbWData, HostAck, Underrun
    );
endinterface

// File: rtl/fb_arbiter.sv
// Shares one single-port 160x120 frame buffer between the display prefetch and host writes.
// Each stored byte covers a 4x4 pixel group; the byte for the next group is fetched ahead.
module fb_arbiter (
    input  logic          clk,
    input  logic          rst,
    fb_arbiter_if.slave   bus,
    output logic [1:0]    state_dbg
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_RD  = 2'd1,
        DISP_CAP = 2'd2,
        HOST_WR  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  next_byte;
    logic        disp_pending;
    logic [14:0] disp_addr;

    logic        group_start;
    logic        active;
    logic        set_line;
    logic        set_wrap;
    logic        disp_set;
    logic        disp_go;
    logic        host_addr_ok;
    logic [9:0]  v_next;
    logic [14:0] row_now;
    logic [14:0] row_next;
    logic [14:0] addr_line;
    logic [14:0] addr_wrap;
    logic [14:0] new_addr;
    logic [14:0] go_addr;

    assign state_dbg = state;

    always_comb begin
        group_start  = bus.PixEn && (bus.Hcounter[1:0] == 2'b00);
        active       = (bus.Hcounter < 10'd640) && (bus.Vcounter < 10'd480);
        v_next       = (bus.Vcounter == 10'd524) ? 10'd0 : bus.Vcounter + 10'd1;
        row_now      = {7'd0, bus.Vcounter[9:2]};
        row_next     = {7'd0, v_next[9:2]};
        // row*160 as row*128 + row*32 keeps the multiply out of the datapath
        addr_line    = (row_now << 7) + (row_now << 5) + {7'd0, bus.Hcounter[9:2]} + 15'd1;
        addr_wrap    = (row_next << 7) + (row_next << 5);
        set_line     = group_start && (bus.Hcounter < 10'd636);
        set_wrap     = group_start && (bus.Hcounter == 10'd796) && (v_next < 10'd480);
        disp_set     = set_line || set_wrap;
        new_addr     = set_line ? addr_line : addr_wrap;
        // A fetch arriving this very cycle counts as seen, so it beats a waiting host
        disp_go      = disp_pending || disp_set;
        go_addr      = disp_set ? new_addr : disp_addr;
        host_addr_ok = bus.HostAddr < 15'd19200;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.PixData  <= 8'h00;
            next_byte    <= 8'h00;
            bus.FbAddr   <= 15'd0;
            bus.FbWData  <= 8'h00;
            bus.FbWe     <= 1'b0;
            bus.HostAck  <= 1'b0;
            disp_pending <= 1'b0;
            disp_addr    <= 15'd0;
            bus.Underrun <= 1'b0;
        end else begin
            if (group_start) begin
                bus.PixData <= active ? next_byte : 8'h00;
            end

            // A new request on top of an unserved one means the older byte is lost
            if (disp_set && disp_pending) begin
                bus.Underrun <= 1'b1;
            end

            if (disp_set) begin
                disp_addr <= new_addr;
            end

            case (state)
                IDLE: begin
                    if (disp_go) begin
                        state        <= DISP_RD;
                        bus.FbAddr   <= go_addr;
                        bus.FbWe     <= 1'b0;
                        disp_pending <= 1'b0;
                    end else if (bus.HostReq) begin
                        state        <= HOST_WR;
                        bus.FbAddr   <= bus.HostAddr;
                        bus.FbWData  <= bus.HostData;
                        bus.FbWe     <= host_addr_ok;
                        bus.HostAck  <= 1'b1;
                        disp_pending <= disp_set;
                    end else begin
                        disp_pending <= disp_set;
                    end
                end
                DISP_RD: begin
                    state        <= DISP_CAP;
                    disp_pending <= disp_pending || disp_set;
                end
                DISP_CAP: begin
                    next_byte    <= bus.FbRData;
                    state        <= IDLE;
                    disp_pending <= disp_pending || disp_set;
                end
                HOST_WR: begin
                    bus.FbWe     <= 1'b0;
                    bus.HostAck  <= 1'b0;
                    state        <= IDLE;
                    disp_pending <= disp_pending || disp_set;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: table of pixel-group vectors plus hand-written
// sequences for fetch priority, host pacing, dropped writes, underrun and reset abort.
module tb_fb_arbiter;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DISP_RD = 2'd1;
    localparam logic [1:0] ST_HOST_WR = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    always #10 clk = ~clk;

    fb_arbiter_if bus();

    fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Frame-buffer RAM model: 1-cycle synchronous read, read-before-write
    logic [7:0] mem [0:19199];
    logic [7:0] rd_tmp;
    always @(posedge clk) begin
        rd_tmp = (bus.FbAddr < 15'd19200) ? mem[bus.FbAddr] : 8'h00;
        if (bus.FbWe && (bus.FbAddr < 15'd19200)) mem[bus.FbAddr] = bus.FbWData;
        bus.FbRData <= rd_tmp;
    end

    int          rd_count = 0;
    int          we_count = 0;
    logic [14:0] last_rd  = 15'd0;
    always @(negedge clk) begin
        if (state_dbg == ST_DISP_RD) begin
            rd_count = rd_count + 1;
            last_rd  = bus.FbAddr;
        end
        if (bus.FbWe) we_count = we_count + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [7:0]  pix;
        logic        fetch;
        logic [14:0] addr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int rd_before;
        int we_before;
        int disp_cyc;
        int ack_cyc;
        int acks;
        int b2b;
        int wes;
        int found;
        logic prev_ack;

        for (int k = 0; k < 19200; k++) mem[k] = 8'(k);

        vecs[0]  = '{10'd796, 10'd524, 8'h00, 1'b1, 15'd0};
        vecs[1]  = '{10'd0,   10'd0,   8'h00, 1'b1, 15'd1};
        vecs[2]  = '{10'd4,   10'd0,   8'h01, 1'b1, 15'd2};
        vecs[3]  = '{10'd632, 10'd4,   8'h02, 1'b1, 15'd319};
        vecs[4]  = '{10'd636, 10'd4,   8'h3F, 1'b0, 15'd0};
        vecs[5]  = '{10'd640, 10'd4,   8'h00, 1'b0, 15'd0};
        vecs[6]  = '{10'd796, 10'd479, 8'h00, 1'b0, 15'd0};
        vecs[7]  = '{10'd0,   10'd100, 8'h3F, 1'b1, 15'd4001};
        vecs[8]  = '{10'd796, 10'd523, 8'h00, 1'b0, 15'd0};
        vecs[9]  = '{10'd8,   10'd479, 8'hA1, 1'b1, 15'd19043};
        vecs[10] = '{10'd700, 10'd200, 8'h00, 1'b0, 15'd0};
        vecs[11] = '{10'd12,  10'd10,  8'h63, 1'b1, 15'd324};
        vecs[12] = '{10'd796, 10'd3,   8'h00, 1'b1, 15'd160};
        vecs[13] = '{10'd16,  10'd4,   8'hA0, 1'b1, 15'd165};
        vecs[14] = '{10'd20,  10'd4,   8'hA5, 1'b1, 15'd166};

        // Clock/reset
        rst          = 1'b1;
        bus.PixEn    = 1'b0;
        bus.Hcounter = 10'd0;
        bus.Vcounter = 10'd0;
        bus.HostReq  = 1'b0;
        bus.HostAddr = 15'd0;
        bus.HostData = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_pixdata",  32'(bus.PixData),  32'h0);
        check("rst_fbaddr",   32'(bus.FbAddr),   32'h0);
        check("rst_fbwe",     32'(bus.FbWe),     32'h0);
        check("rst_fbwdata",  32'(bus.FbWData),  32'h0);
        check("rst_hostack",  32'(bus.HostAck),  32'h0);
        check("rst_underrun", 32'(bus.Underrun), 32'h0);
        check("rst_state",    32'(state_dbg),    32'(ST_IDLE));
        rst = 1'b0;

        // Table: one group start per 8-clk slot, then let the prefetch settle
        we_before = we_count;
        for (int i = 0; i < 15; i++) begin
            rd_before = rd_count;
            @(negedge clk);
            bus.Hcounter = vecs[i].h;
            bus.Vcounter = vecs[i].v;
            bus.PixEn    = 1'b1;
            @(negedge clk);
            check($sformatf("pix[%0d]", i), 32'(bus.PixData), 32'(vecs[i].pix));
            bus.PixEn = 1'b0;
            repeat (7) @(negedge clk);
            #2;
            check($sformatf("fetch[%0d]", i), 32'(rd_count - rd_before), 32'(vecs[i].fetch));
            if (vecs[i].fetch) check($sformatf("rdaddr[%0d]", i), 32'(last_rd), 32'(vecs[i].addr));
        end
        check("table_no_we", 32'(we_count - we_before), 32'h0);

        // Fetch and host request arriving together: read first, then the write
        @(negedge clk);
        bus.Hcounter = 10'd24;
        bus.Vcounter = 10'd4;
        bus.PixEn    = 1'b1;
        bus.HostReq  = 1'b1;
        bus.HostAddr = 15'd100;
        bus.HostData = 8'hE0;
        disp_cyc = -1;
        ack_cyc  = -1;
        acks     = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("prio_pix", 32'(bus.PixData), 32'hA6);
                bus.PixEn = 1'b0;
            end
            if ((state_dbg == ST_DISP_RD) && (disp_cyc < 0)) disp_cyc = c;
            if (bus.HostAck) begin
                acks = acks + 1;
                if (ack_cyc < 0) ack_cyc = c;
                bus.HostReq = 1'b0;
            end
        end
        check("prio_disp_cycle", 32'(disp_cyc), 32'd1);
        check("prio_ack_cycle",  32'(ack_cyc),  32'd4);
        check("prio_ack_count",  32'(acks),     32'd1);
        check("prio_mem100",     32'(mem[100]), 32'hE0);

        // Blanking: a held request gets every other cycle, never back to back
        bus.Hcounter = 10'd700;
        bus.HostReq  = 1'b1;
        bus.HostAddr = 15'd200;
        bus.HostData = 8'h5A;
        acks     = 0;
        b2b      = 0;
        prev_ack = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.HostAck) acks = acks + 1;
            if (bus.HostAck && prev_ack) b2b = b2b + 1;
            prev_ack = bus.HostAck;
        end
        bus.HostReq = 1'b0;
        repeat (3) @(negedge clk);
        check("pace_ack_count", 32'(acks),     32'd5);
        check("pace_b2b",       32'(b2b),      32'd0);
        check("pace_mem200",    32'(mem[200]), 32'h5A);

        // Out-of-range host address: acknowledged, never written
        bus.HostReq  = 1'b1;
        bus.HostAddr = 15'd19200;
        bus.HostData = 8'hFF;
        acks = 0;
        wes  = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.FbWe) wes = wes + 1;
            if (bus.HostAck) begin
                acks = acks + 1;
                bus.HostReq = 1'b0;
            end
        end
        check("drop_ack_count", 32'(acks), 32'd1);
        check("drop_we_count",  32'(wes),  32'd0);
        check("underrun_quiet", 32'(bus.Underrun), 32'h0);

        // Group start every clock with a busy host: fetches collide
        bus.Hcounter = 10'd0;
        bus.Vcounter = 10'd0;
        bus.PixEn    = 1'b1;
        bus.HostReq  = 1'b1;
        bus.HostAddr = 15'd300;
        bus.HostData = 8'h11;
        repeat (12) @(negedge clk);
        bus.PixEn    = 1'b0;
        bus.HostReq  = 1'b0;
        bus.Hcounter = 10'd700;
        repeat (20) @(negedge clk);
        check("underrun_sticky", 32'(bus.Underrun), 32'h1);

        // Reset while a host write is in flight
        bus.HostReq  = 1'b1;
        bus.HostAddr = 15'd301;
        bus.HostData = 8'h77;
        found = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if ((found == 0) && (state_dbg == ST_HOST_WR)) begin
                found = 1;
                rst   = 1'b1;
                bus.HostReq = 1'b0;
            end
        end
        check("abort_reached_host_wr", 32'(found), 32'd1);
        check("abort_fbwe",     32'(bus.FbWe),     32'h0);
        check("abort_hostack",  32'(bus.HostAck),  32'h0);
        check("abort_pixdata",  32'(bus.PixData),  32'h0);
        check("abort_fbaddr",   32'(bus.FbAddr),   32'h0);
        check("abort_fbwdata",  32'(bus.FbWData),  32'h0);
        check("abort_underrun", 32'(bus.Underrun), 32'h0);
        check("abort_state",    32'(state_dbg),    32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
